// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM encoding, IF/ID register controls and bus word types.
package if_stage_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    localparam word_addr_t RESET_VECTOR_DEFAULT = 30'h0;
    localparam word_data_t NOP_INSN_DEFAULT     = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef enum logic [1:0] {
        REG_HOLD    = 2'd0,
        REG_LOAD    = 2'd1,
        REG_BUBBLE  = 2'd2,
        REG_RESTORE = 2'd3
    } reg_ctrl_e;

endpackage

// File: rtl/if_reg.sv
// IF/ID pipeline register plus the one-entry skid buffer that catches a word
// arriving on the same cycle as a stall.
module if_reg
    import if_stage_pkg::*;
#(
    parameter word_data_t NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  reg_ctrl_e  i_ctrl,
    input  logic       i_bufSave,
    input  word_addr_t i_pc,
    input  word_data_t i_insn,
    output word_addr_t o_pc,
    output word_data_t o_insn,
    output logic       o_en_
);

    word_addr_t r_ifPc;
    word_data_t r_ifInsn;
    logic       r_ifEn_;
    word_addr_t r_bufPc;
    word_data_t r_bufInsn;

    // A bubble keeps if_pc so ID still sees the PC of the last real entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifPc   <= '0;
            r_ifInsn <= NOP_INSN;
            r_ifEn_  <= 1'b1;
        end else begin
            case (i_ctrl)
                REG_LOAD: begin
                    r_ifPc   <= i_pc;
                    r_ifInsn <= i_insn;
                    r_ifEn_  <= 1'b0;
                end
                REG_BUBBLE: begin
                    r_ifInsn <= NOP_INSN;
                    r_ifEn_  <= 1'b1;
                end
                REG_RESTORE: begin
                    r_ifPc   <= r_bufPc;
                    r_ifInsn <= r_bufInsn;
                    r_ifEn_  <= 1'b0;
                end
                default: begin
                    r_ifPc   <= r_ifPc;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bufPc   <= '0;
            r_bufInsn <= '0;
        end else if (i_bufSave) begin
            r_bufPc   <= i_pc;
            r_bufInsn <= i_insn;
        end
    end

    assign o_pc   = r_ifPc;
    assign o_insn = r_ifInsn;
    assign o_en_  = r_ifEn_;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, masters the instruction bus and
// steers the IF/ID register through flush, stall and branch redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter word_addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter word_data_t NOP_INSN     = NOP_INSN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  word_addr_t new_pc,
    input  logic       br_taken,
    input  word_addr_t br_addr,
    output logic       bus_req_,
    output word_addr_t bus_addr,
    input  logic       bus_rdy_,
    input  word_data_t bus_rd_data,
    output word_addr_t if_pc,
    output word_data_t if_insn,
    output logic       if_en_,
    output logic       busy
);

    fetch_state_e r_state;
    fetch_state_e w_stateNext;
    word_addr_t   r_pc;
    word_addr_t   w_pcNext;
    reg_ctrl_e    w_regCtrl;
    logic         w_bufSave;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

    // Priority is flush > stall > branch > normal; a branch seen during a
    // stall is ignored because ID re-presents it once the stall clears.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_regCtrl   = REG_HOLD;
        w_bufSave   = 1'b0;
        case (r_state)
            FETCH: begin
                if (flush) begin
                    w_pcNext  = new_pc;
                    w_regCtrl = REG_BUBBLE;
                end else if (stall) begin
                    if (!bus_rdy_) begin
                        w_bufSave   = 1'b1;
                        w_pcNext    = r_pc + 30'd1;
                        w_stateNext = HOLD;
                    end
                end else if (br_taken) begin
                    w_pcNext  = br_addr;
                    w_regCtrl = REG_BUBBLE;
                end else if (!bus_rdy_) begin
                    w_pcNext  = r_pc + 30'd1;
                    w_regCtrl = REG_LOAD;
                end else begin
                    w_regCtrl = REG_BUBBLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_pcNext    = new_pc;
                    w_regCtrl   = REG_BUBBLE;
                    w_stateNext = FETCH;
                end else if (stall) begin
                    w_stateNext = HOLD;
                end else if (br_taken) begin
                    w_pcNext    = br_addr;
                    w_regCtrl   = REG_BUBBLE;
                    w_stateNext = FETCH;
                end else begin
                    w_regCtrl   = REG_RESTORE;
                    w_stateNext = FETCH;
                end
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

    assign bus_addr = r_pc;
    assign bus_req_ = (r_state == HOLD);
    assign busy     = (r_state == FETCH) && bus_rdy_;

    if_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_ifReg (
        .clk       (clk),
        .reset     (reset),
        .i_ctrl    (w_regCtrl),
        .i_bufSave (w_bufSave),
        .i_pc      (r_pc),
        .i_insn    (bus_rd_data),
        .o_pc      (if_pc),
        .o_insn    (if_insn),
        .o_en_     (if_en_)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a queue-based reference model predicts bus
// and IF/ID outputs for every cycle, and a monitor compares them.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, br_taken, bus_rdy_;
    logic [29:0] new_pc, br_addr;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic [31:0] bus_rd_data;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en_;
    logic        busy;
    logic [31:0] garbage;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
    } entry_t;

    typedef struct packed {
        logic        expBusy;
        logic [29:0] expAddr;
        logic        expReq_;
        logic [29:0] expPc;
        logic [31:0] expInsn;
        logic        expEn_;
    } record_t;

    record_t     sbQ[$];
    entry_t      heldQ[$];
    logic [29:0] mPc;
    logic [29:0] mIfPc;
    logic [31:0] mIfInsn;
    logic        mIfEn_;

    function automatic logic [31:0] memWord(input logic [29:0] a);
        return {2'b00, a} + 32'h100;
    endfunction

    assign bus_rd_data = bus_rdy_ ? garbage : memWord(bus_addr);

    always #5 clk = ~clk;

    if_stage #(
        .RESET_VECTOR (30'h0),
        .NOP_INSN     (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .bus_req_    (bus_req_),
        .bus_addr    (bus_addr),
        .bus_rdy_    (bus_rdy_),
        .bus_rd_data (bus_rd_data),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en_      (if_en_),
        .busy        (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs at a negedge, predicts the outcome from the
    // fetch rules, queues it for the monitor, then waits for the next negedge.
    task automatic applyStimulus(input bit st, input bit fl, input logic [29:0] np,
                                 input bit br, input logic [29:0] ba, input bit rdyN);
        record_t     rec;
        entry_t      e;
        logic [31:0] data;
        bit          gotWord;
        stall    = st;
        flush    = fl;
        new_pc   = np;
        br_taken = br;
        br_addr  = ba;
        bus_rdy_ = rdyN;
        garbage  = $urandom;
        rec.expBusy = (heldQ.size() == 0) && rdyN;
        rec.expAddr = mPc;
        rec.expReq_ = (heldQ.size() != 0);
        data    = memWord(mPc);
        gotWord = !rdyN && (heldQ.size() == 0);
        if (fl) begin
            heldQ.delete();
            mPc = np;
            mIfInsn = NOP;
            mIfEn_ = 1'b1;
        end else if (heldQ.size() != 0) begin
            if (!st) begin
                if (br) begin
                    heldQ.delete();
                    mPc = ba;
                    mIfInsn = NOP;
                    mIfEn_ = 1'b1;
                end else begin
                    e = heldQ.pop_front();
                    mIfPc = e.pc;
                    mIfInsn = e.insn;
                    mIfEn_ = 1'b0;
                end
            end
        end else if (st) begin
            if (gotWord) begin
                heldQ.push_back('{pc: mPc, insn: data});
                mPc = mPc + 30'd1;
            end
        end else if (br) begin
            mPc = ba;
            mIfInsn = NOP;
            mIfEn_ = 1'b1;
        end else if (gotWord) begin
            mIfPc = mPc;
            mIfInsn = data;
            mIfEn_ = 1'b0;
            mPc = mPc + 30'd1;
        end else begin
            mIfInsn = NOP;
            mIfEn_ = 1'b1;
        end
        rec.expPc   = mIfPc;
        rec.expInsn = mIfInsn;
        rec.expEn_  = mIfEn_;
        sbQ.push_back(rec);
        @(negedge clk);
    endtask

    // Monitor: pre-edge bus/busy values just after inputs settle, IF/ID #1 after the edge.
    initial begin
        record_t r;
        forever begin
            @(negedge clk);
            #2;
            if (sbQ.size() > 0) begin
                r = sbQ.pop_front();
                checkOutput("busy", {31'b0, busy}, {31'b0, r.expBusy});
                checkOutput("bus_addr", {2'b0, bus_addr}, {2'b0, r.expAddr});
                checkOutput("bus_req_", {31'b0, bus_req_}, {31'b0, r.expReq_});
                @(posedge clk);
                #1;
                checkOutput("if_pc", {2'b0, if_pc}, {2'b0, r.expPc});
                checkOutput("if_insn", if_insn, r.expInsn);
                checkOutput("if_en_", {31'b0, if_en_}, {31'b0, r.expEn_});
            end
        end
    end

    initial begin
        reset = 1'b1;
        stall = 0; flush = 0; br_taken = 0; bus_rdy_ = 1;
        new_pc = '0; br_addr = '0; garbage = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_if_pc", {2'b0, if_pc}, 32'h0);
        checkOutput("rst_if_insn", if_insn, NOP);
        checkOutput("rst_if_en_", {31'b0, if_en_}, 32'h1);
        checkOutput("rst_bus_addr", {2'b0, bus_addr}, 32'h0);
        checkOutput("rst_bus_req_", {31'b0, bus_req_}, 32'h0);
        mPc = 30'h0; mIfPc = 30'h0; mIfInsn = NOP; mIfEn_ = 1'b1;
        heldQ.delete();
        reset = 1'b0;

        // Zero-wait run, two wait states at pc 5, then a stall catching pc 7.
        repeat (5) applyStimulus(0, 0, '0, 0, '0, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 1);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 0);
        applyStimulus(1, 0, '0, 0, '0, 0);
        repeat (2) applyStimulus(1, 0, '0, 0, '0, 1);
        applyStimulus(0, 0, '0, 0, '0, 1);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 0);

        // Branch in FETCH with data returning, then branch out of HOLD.
        applyStimulus(0, 0, '0, 1, 30'h40, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 0);
        applyStimulus(1, 0, '0, 0, '0, 0);
        applyStimulus(0, 0, '0, 1, 30'h40, 1);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 0);

        // Flush beats stall and branch while in HOLD.
        applyStimulus(1, 0, '0, 0, '0, 0);
        applyStimulus(1, 1, 30'h10, 1, 30'h55, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [29:0] np, ba;
            np = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE : 30'($urandom);
            ba = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFF : 30'($urandom);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, np,
                          $urandom_range(0, 9) == 0, ba, $urandom_range(0, 9) < 3);
        end

        // PC wrap, then a waiting bus before the mid-cycle reset.
        applyStimulus(0, 1, 30'h3FFFFFFF, 0, '0, 0);
        repeat (3) applyStimulus(0, 0, '0, 0, '0, 0);
        repeat (2) applyStimulus(0, 0, '0, 0, '0, 1);

        repeat (3) @(negedge clk);
        if (sbQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: %0d records left, required 0", sbQ.size());
        end

        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_if_pc", {2'b0, if_pc}, 32'h0);
        checkOutput("async_if_insn", if_insn, NOP);
        checkOutput("async_if_en_", {31'b0, if_en_}, 32'h1);
        checkOutput("async_bus_addr", {2'b0, bus_addr}, 32'h0);
        checkOutput("async_bus_req_", {31'b0, bus_req_}, 32'h0);
        checkOutput("async_busy", {31'b0, busy}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
